// File: rtl/sd_spi_card_model_if.sv
// SPI-mode SD link between a host (master) and the card model (slave).
// Mode 0: SD_clk idles low, data sampled on the rising edge, changed on the
// falling edge. SD_cs is active low and frames byte alignment.
interface sd_spi_card_model_if;
    logic SD_clk;
    logic SD_cs;
    logic SD_datain;
    logic SD_dataout;

    modport master (output SD_clk, output SD_cs, output SD_datain, input SD_dataout);
    modport slave  (input SD_clk, input SD_cs, input SD_datain, output SD_dataout);
endinterface

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder. Oversamples the host pins on clk, decodes
// 6-byte command frames, answers R1/R3/R7 and serves single-block reads and
// writes through a byte-wide backing-store port.
//
// Backing-store port protocol: rd_en and wr_en are single-cycle strobes with
// no back-pressure. A read strobe requests byte byte_idx and rd_data must be
// valid on the cycle after rd_en; a write strobe presents wr_data/byte_idx for
// that one cycle only.
module sd_spi_card_model #(
    parameter int unsigned INIT_POLLS = 2,
    parameter int unsigned NCR_BYTES  = 1,
    parameter int unsigned NAC_BYTES  = 2,
    parameter int unsigned BUSY_BYTES = 4,
    parameter logic [31:0] OCR        = 32'h80FF8000
) (
    input  logic                      clk,
    input  logic                      rst,
    sd_spi_card_model_if.slave        spi,
    output logic [31:0]               blk_addr,
    output logic [8:0]                byte_idx,
    output logic                      rd_en,
    input  logic [7:0]                rd_data,
    output logic                      wr_en,
    output logic [7:0]                wr_data,
    output logic [5:0]                cmd_o,
    output logic                      cmd_valid,
    output logic                      idle_o,
    output logic [3:0]                dbg_state
);

    typedef enum logic [3:0] {
        HUNT, CMD_RX, NCR, RESP, RD_NAC, RD_TOK, RD_DATA, RD_CRC,
        WR_TOK, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
    } state_t;

    typedef enum logic [1:0] { K_NONE, K_RD, K_WR } kind_t;

    localparam logic [7:0] NCR_LAST  = 8'(NCR_BYTES - 1);
    localparam logic [7:0] NAC_LAST  = 8'(NAC_BYTES - 1);
    localparam logic [7:0] BUSY_LAST = 8'(BUSY_BYTES - 1);
    localparam logic [7:0] INIT_CNT  = 8'(INIT_POLLS);

    // Pin synchronisers and edge detection
    logic [1:0] sclk_s, cs_s, mosi_s;
    logic       sclk_d;
    logic       cs_hi, sclk_rise, sclk_fall;

    // Byte framing
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic       byte_done;

    // MISO shifter; tx_next is the byte owed in the next byte slot
    logic       miso;
    logic [7:0] tx_shift, tx_next;

    // FSM; state names the byte slot currently on the wire
    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx, tx_nx;
    logic [8:0] data_cnt, data_nx;
    logic       do_exec, rd_first, rd_next, rd_wrap, wr_go;

    // Command context
    logic [5:0]  cmd_idx;
    logic [31:0] arg;
    logic [7:0]  polls;
    logic        acmd;
    logic [7:0]  r1;
    logic [31:0] ext;
    logic        has_ext;
    kind_t       kind;

    logic       rd_pend;
    logic [7:0] rd_buf;

    assign cs_hi     = cs_s[1];
    assign sclk_rise =  sclk_s[1] & ~sclk_d & ~cs_hi;
    assign sclk_fall = ~sclk_s[1] &  sclk_d & ~cs_hi;
    assign rx_byte   = {rx_shift, mosi_s[1]};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    assign spi.SD_dataout = miso;
    assign dbg_state      = state;

    // Two-flop synchronisers on the asynchronous host pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b11;
            sclk_d <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], spi.SD_clk};
            cs_s   <= {cs_s[0], spi.SD_cs};
            mosi_s <= {mosi_s[0], spi.SD_datain};
            sclk_d <= sclk_s[1];
        end
    end

    // Shift MOSI in on each SD_clk rise; chip select high realigns bytes
    always_ff @(posedge clk) begin
        if (rst || cs_hi) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
        end else if (sclk_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
        end
    end

    // Drive MISO on each SD_clk fall; the fall that ends a byte loads the next
    always_ff @(posedge clk) begin
        if (rst || cs_hi) begin
            miso     <= 1'b1;
            tx_shift <= 8'hFF;
        end else if (sclk_fall) begin
            if (bit_cnt == 3'd0) begin
                miso     <= tx_next[7];
                tx_shift <= {tx_next[6:0], 1'b1};
            end else begin
                miso     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
        end
    end

    // FSM state register, advanced once per completed byte slot
    always_ff @(posedge clk) begin
        if (rst || cs_hi) begin
            state    <= HUNT;
            cnt      <= 8'd0;
            data_cnt <= 9'd0;
            tx_next  <= 8'hFF;
        end else if (byte_done) begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            data_cnt <= data_nx;
            tx_next  <= tx_nx;
        end
    end

    // Next slot decision: next state, byte owed next, port strobes
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        data_nx  = data_cnt;
        tx_nx    = 8'hFF;
        do_exec  = 1'b0;
        rd_first = 1'b0;
        rd_next  = 1'b0;
        rd_wrap  = 1'b0;
        wr_go    = 1'b0;
        if (byte_done) begin
            case (state)
                HUNT: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        state_nx = CMD_RX;
                        cnt_nx   = 8'd0;
                    end
                end
                CMD_RX: begin
                    if (cnt == 8'd4) begin
                        state_nx = NCR;
                        cnt_nx   = 8'd0;
                        do_exec  = 1'b1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                NCR: begin
                    if (cnt == NCR_LAST) begin
                        state_nx = RESP;
                        cnt_nx   = 8'd0;
                        tx_nx    = r1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (cnt == (has_ext ? 8'd4 : 8'd0)) begin
                        cnt_nx = 8'd0;
                        case (kind)
                            K_RD:    state_nx = RD_NAC;
                            K_WR:    state_nx = WR_TOK;
                            default: state_nx = HUNT;
                        endcase
                    end else begin
                        cnt_nx = cnt + 8'd1;
                        tx_nx  = ext[31:24];
                    end
                end
                RD_NAC: begin
                    if (cnt == NAC_LAST) begin
                        state_nx = RD_TOK;
                        tx_nx    = 8'hFE;
                        rd_first = 1'b1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                RD_TOK: begin
                    state_nx = RD_DATA;
                    data_nx  = 9'd0;
                    tx_nx    = rd_buf;
                    rd_next  = 1'b1;
                end
                RD_DATA: begin
                    if (data_cnt == 9'd511) begin
                        state_nx = RD_CRC;
                        cnt_nx   = 8'd0;
                        rd_wrap  = 1'b1;
                    end else begin
                        data_nx = data_cnt + 9'd1;
                        tx_nx   = rd_buf;
                        rd_next = (byte_idx != 9'd511);
                    end
                end
                RD_CRC: begin
                    if (cnt == 8'd1) state_nx = HUNT;
                    else             cnt_nx   = cnt + 8'd1;
                end
                WR_TOK: begin
                    if (rx_byte == 8'hFE) begin
                        state_nx = WR_DATA;
                        data_nx  = 9'd0;
                    end
                end
                WR_DATA: begin
                    wr_go = 1'b1;
                    if (data_cnt == 9'd511) begin
                        state_nx = WR_CRC;
                        cnt_nx   = 8'd0;
                    end else begin
                        data_nx = data_cnt + 9'd1;
                    end
                end
                WR_CRC: begin
                    if (cnt == 8'd1) begin
                        state_nx = WR_RESP;
                        tx_nx    = 8'h05;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                WR_RESP: begin
                    if (BUSY_BYTES == 0) begin
                        state_nx = HUNT;
                    end else begin
                        state_nx = WR_BUSY;
                        cnt_nx   = 8'd0;
                        tx_nx    = 8'h00;
                    end
                end
                WR_BUSY: begin
                    if (cnt == BUSY_LAST) begin
                        state_nx = HUNT;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                        tx_nx  = 8'h00;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Command capture and execution; card status survives chip-select aborts
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_idx   <= 6'd0;
            arg       <= 32'd0;
            cmd_o     <= 6'd0;
            cmd_valid <= 1'b0;
            idle_o    <= 1'b1;
            polls     <= 8'd0;
            acmd      <= 1'b0;
            blk_addr  <= 32'd0;
            r1        <= 8'hFF;
            ext       <= 32'd0;
            has_ext   <= 1'b0;
            kind      <= K_NONE;
        end else begin
            cmd_valid <= do_exec;
            if (byte_done && state == HUNT)
                cmd_idx <= rx_byte[5:0];
            if (byte_done && state == CMD_RX && cnt != 8'd4)
                arg <= {arg[23:0], rx_byte};
            if (byte_done && state == RESP)
                ext <= {ext[23:0], 8'h00};
            if (do_exec) begin
                cmd_o   <= cmd_idx;
                acmd    <= (cmd_idx == 6'd55);
                has_ext <= 1'b0;
                kind    <= K_NONE;
                r1      <= {7'd0, idle_o};
                case (cmd_idx)
                    6'd0: begin
                        idle_o <= 1'b1;
                        polls  <= 8'd0;
                        r1     <= 8'h01;
                    end
                    6'd8: begin
                        ext     <= {20'h0, arg[11:0]};
                        has_ext <= 1'b1;
                    end
                    6'd55: ;
                    6'd41: begin
                        if (!acmd) begin
                            r1 <= {5'd0, 1'b1, 1'b0, idle_o};
                        end else if (polls < INIT_CNT) begin
                            polls <= polls + 8'd1;
                            r1    <= 8'h01;
                        end else begin
                            idle_o <= 1'b0;
                            r1     <= 8'h00;
                        end
                    end
                    6'd58: begin
                        ext     <= OCR;
                        has_ext <= 1'b1;
                    end
                    6'd17, 6'd24: begin
                        if (idle_o) begin
                            r1 <= {5'd0, 1'b1, 1'b0, idle_o};
                        end else begin
                            blk_addr <= arg;
                            r1       <= 8'h00;
                            kind     <= (cmd_idx == 6'd17) ? K_RD : K_WR;
                        end
                    end
                    default: r1 <= {5'd0, 1'b1, 1'b0, idle_o};
                endcase
            end
        end
    end

    // Backing-store port: prefetch read bytes one slot ahead, strobe writes
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en    <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= 8'd0;
            byte_idx <= 9'd0;
            rd_pend  <= 1'b0;
            rd_buf   <= 8'hFF;
        end else begin
            rd_en   <= rd_first | rd_next;
            wr_en   <= wr_go;
            rd_pend <= rd_en;
            if (rd_pend)
                rd_buf <= rd_data;
            if (rd_first) begin
                byte_idx <= 9'd0;
            end else if (rd_next) begin
                byte_idx <= byte_idx + 9'd1;
            end else if (wr_go) begin
                byte_idx <= data_cnt;
                wr_data  <= rx_byte;
            end else if (rd_wrap) begin
                byte_idx <= 9'd0;
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_card_model.sv
// Directed bench for the SD SPI card model: the bench plays the host.
`timescale 1ns/1ps
module tb_sd_spi_card_model;

    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] blk_addr;
    logic [8:0]  byte_idx;
    logic        rd_en;
    logic [7:0]  rd_data = 8'h00;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [5:0]  cmd_o;
    logic        cmd_valid;
    logic        idle_o;
    logic [3:0]  dbg_state;

    int asserts  = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int cmdv_cnt = 0;
    int wr_bad   = 0;
    logic [16:0] exp_q[$];

    sd_spi_card_model_if spi();

    sd_spi_card_model dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .blk_addr  (blk_addr),
        .byte_idx  (byte_idx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cmd_o     (cmd_o),
        .cmd_valid (cmd_valid),
        .idle_o    (idle_o),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Backing store model (rd_data = low byte of index) and strobe monitor
    always @(negedge clk) begin
        if (rd_en) begin
            rd_data <= byte_idx[7:0];
            rd_cnt  <= rd_cnt + 1;
        end
        if (cmd_valid)
            cmdv_cnt <= cmdv_cnt + 1;
        if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (exp_q.size() == 0) begin
                wr_bad <= wr_bad + 1;
            end else begin
                if ({byte_idx, wr_data} !== exp_q[0])
                    wr_bad <= wr_bad + 1;
                void'(exp_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Host driver: one mode-0 byte exchange, MSB first
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi.SD_datain = tx[i];
            #(HALF);
            rx[i] = spi.SD_dataout;
            spi.SD_clk = 1'b1;
            #(HALF);
            spi.SD_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] rx;
        xfer({2'b01, idx}, rx);
        xfer(arg[31:24], rx);
        xfer(arg[23:16], rx);
        xfer(arg[15:8], rx);
        xfer(arg[7:0], rx);
        xfer(crc, rx);
    endtask

    task automatic test_reset();
        asserts++; if (spi.SD_dataout !== 1'b1) begin failures++; $display("FAIL reset_miso: got %b expected 1", spi.SD_dataout); end
        asserts++; if (idle_o !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", idle_o); end
        asserts++; if (blk_addr !== 32'd0) begin failures++; $display("FAIL reset_blk_addr: got %h expected 0", blk_addr); end
        asserts++; if (byte_idx !== 9'd0) begin failures++; $display("FAIL reset_byte_idx: got %0d expected 0", byte_idx); end
        asserts++; if (cmd_o !== 6'd0) begin failures++; $display("FAIL reset_cmd_o: got %0d expected 0", cmd_o); end
        asserts++; if ({rd_en, wr_en, cmd_valid} !== 3'b000) begin failures++; $display("FAIL reset_strobes: got %b expected 000", {rd_en, wr_en, cmd_valid}); end
        asserts++; if (dbg_state !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_idle_ff();
        logic [7:0] rx;
        int bad = 0;
        spi.SD_cs = 1'b0;
        #(100);
        for (int i = 0; i < 16; i++) begin
            xfer(8'hFF, rx);
            if (rx !== 8'hFF) bad++;
        end
        asserts++; if (bad !== 0) begin failures++; $display("FAIL idle_miso: %0d bytes not FF, expected 0", bad); end
        asserts++; if (cmdv_cnt !== 0) begin failures++; $display("FAIL idle_cmd_valid: got %0d expected 0", cmdv_cnt); end
        asserts++; if (idle_o !== 1'b1) begin failures++; $display("FAIL idle_flag: got %b expected 1", idle_o); end
    endtask

    task automatic test_cmd0();
        logic [7:0] rx;
        int c0 = cmdv_cnt;
        send_cmd(6'd0, 32'd0, 8'h95);
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'hFF) begin failures++; $display("FAIL cmd0_ncr: got %h expected ff", rx); end
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'h01) begin failures++; $display("FAIL cmd0_r1: got %h expected 01", rx); end
        asserts++; if (cmdv_cnt !== c0 + 1) begin failures++; $display("FAIL cmd0_valid: got %0d expected %0d", cmdv_cnt, c0 + 1); end
        asserts++; if (cmd_o !== 6'd0) begin failures++; $display("FAIL cmd0_cmd_o: got %0d expected 0", cmd_o); end
    endtask

    task automatic test_cmd8_cmd58();
        logic [7:0] rx;
        logic [7:0] e8 [6];
        logic [7:0] e58 [6];
        e8  = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        e58 = '{8'hFF, 8'h01, 8'h80, 8'hFF, 8'h80, 8'h00};
        send_cmd(6'd8, 32'h000001AA, 8'h87);
        for (int i = 0; i < 6; i++) begin
            xfer(8'hFF, rx);
            asserts++; if (rx !== e8[i]) begin failures++; $display("FAIL cmd8_resp[%0d]: got %h expected %h", i, rx, e8[i]); end
        end
        asserts++; if (cmd_o !== 6'd8) begin failures++; $display("FAIL cmd8_cmd_o: got %0d expected 8", cmd_o); end
        send_cmd(6'd58, 32'd0, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            xfer(8'hFF, rx);
            asserts++; if (rx !== e58[i]) begin failures++; $display("FAIL cmd58_resp[%0d]: got %h expected %h", i, rx, e58[i]); end
        end
    endtask

    task automatic test_illegal_read();
        logic [7:0] rx;
        send_cmd(6'd17, 32'd3, 8'hFF);
        xfer(8'hFF, rx);
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'h05) begin failures++; $display("FAIL illegal_r1: got %h expected 05", rx); end
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'hFF) begin failures++; $display("FAIL illegal_after: got %h expected ff", rx); end
        asserts++; if (blk_addr !== 32'd0) begin failures++; $display("FAIL illegal_blk_addr: got %h expected 0", blk_addr); end
    endtask

    task automatic test_acmd41();
        logic [7:0] rx;
        logic [7:0] exp_r1 [3];
        logic       exp_idle [3];
        exp_r1   = '{8'h01, 8'h01, 8'h00};
        exp_idle = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send_cmd(6'd55, 32'd0, 8'hFF);
            xfer(8'hFF, rx);
            xfer(8'hFF, rx);
            asserts++; if (rx !== 8'h01) begin failures++; $display("FAIL cmd55_r1[%0d]: got %h expected 01", i, rx); end
            send_cmd(6'd41, 32'h40000000, 8'hFF);
            xfer(8'hFF, rx);
            xfer(8'hFF, rx);
            asserts++; if (rx !== exp_r1[i]) begin failures++; $display("FAIL acmd41_r1[%0d]: got %h expected %h", i, rx, exp_r1[i]); end
            asserts++; if (idle_o !== exp_idle[i]) begin failures++; $display("FAIL acmd41_idle[%0d]: got %b expected %b", i, idle_o, exp_idle[i]); end
        end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        logic [7:0] hdr [5];
        logic [7:0] ev;
        int r0 = rd_cnt;
        hdr = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE};
        send_cmd(6'd17, 32'd5, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            xfer(8'hFF, rx);
            asserts++; if (rx !== hdr[i]) begin failures++; $display("FAIL rd_hdr[%0d]: got %h expected %h", i, rx, hdr[i]); end
        end
        for (int k = 0; k < 512; k++) begin
            ev = k[7:0];
            xfer(8'hFF, rx);
            asserts++; if (rx !== ev) begin failures++; $display("FAIL rd_data[%0d]: got %h expected %h", k, rx, ev); end
        end
        for (int i = 0; i < 3; i++) begin
            xfer(8'hFF, rx);
            asserts++; if (rx !== 8'hFF) begin failures++; $display("FAIL rd_tail[%0d]: got %h expected ff", i, rx); end
        end
        asserts++; if (rd_cnt - r0 !== 512) begin failures++; $display("FAIL rd_en_count: got %0d expected 512", rd_cnt - r0); end
        asserts++; if (blk_addr !== 32'd5) begin failures++; $display("FAIL rd_blk_addr: got %h expected 5", blk_addr); end
        asserts++; if (byte_idx !== 9'd0) begin failures++; $display("FAIL rd_byte_idx_wrap: got %0d expected 0", byte_idx); end
    endtask

    task automatic test_write();
        logic [7:0] rx;
        logic [7:0] d;
        logic [8:0] ki;
        int w0 = wr_cnt;
        send_cmd(6'd24, 32'd9, 8'hFF);
        xfer(8'hFF, rx);
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'h00) begin failures++; $display("FAIL wr_r1: got %h expected 00", rx); end
        xfer(8'hFF, rx);
        xfer(8'hFE, rx);
        for (int k = 0; k < 512; k++) begin
            d  = 8'(k * 7 + 3);
            ki = k[8:0];
            exp_q.push_back({ki, d});
            xfer(d, rx);
        end
        xfer(8'h12, rx);
        xfer(8'h34, rx);
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'h05) begin failures++; $display("FAIL wr_data_resp: got %h expected 05", rx); end
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, rx);
            asserts++; if (rx !== 8'h00) begin failures++; $display("FAIL wr_busy[%0d]: got %h expected 00", i, rx); end
        end
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'hFF) begin failures++; $display("FAIL wr_after_busy: got %h expected ff", rx); end
        repeat (4) @(negedge clk);
        asserts++; if (wr_cnt - w0 !== 512) begin failures++; $display("FAIL wr_en_count: got %0d expected 512", wr_cnt - w0); end
        asserts++; if (wr_bad !== 0) begin failures++; $display("FAIL wr_payload: got %0d bad strobes expected 0", wr_bad); end
        asserts++; if (exp_q.size() !== 0) begin failures++; $display("FAIL wr_missing: got %0d unwritten expected 0", exp_q.size()); end
        asserts++; if (blk_addr !== 32'd9) begin failures++; $display("FAIL wr_blk_addr: got %h expected 9", blk_addr); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic [7:0] d;
        logic [8:0] ki;
        logic [7:0] e58 [6];
        int w0 = wr_cnt;
        e58 = '{8'hFF, 8'h00, 8'h80, 8'hFF, 8'h80, 8'h00};
        send_cmd(6'd24, 32'd11, 8'hFF);
        xfer(8'hFF, rx);
        xfer(8'hFF, rx);
        asserts++; if (rx !== 8'h00) begin failures++; $display("FAIL abort_r1: got %h expected 00", rx); end
        xfer(8'hFE, rx);
        for (int k = 0; k < 20; k++) begin
            d  = 8'(8'hA0 + k);
            ki = k[8:0];
            exp_q.push_back({ki, d});
            xfer(d, rx);
        end
        #(HALF);
        spi.SD_cs = 1'b1;
        repeat (20) @(negedge clk);
        asserts++; if (dbg_state !== 4'd0) begin failures++; $display("FAIL abort_state: got %0d expected 0", dbg_state); end
        asserts++; if (spi.SD_dataout !== 1'b1) begin failures++; $display("FAIL abort_miso: got %b expected 1", spi.SD_dataout); end
        asserts++; if (wr_cnt - w0 !== 20) begin failures++; $display("FAIL abort_wr_count: got %0d expected 20", wr_cnt - w0); end
        asserts++; if (wr_bad !== 0 || exp_q.size() !== 0) begin failures++; $display("FAIL abort_payload: got bad=%0d pending=%0d expected 0/0", wr_bad, exp_q.size()); end
        asserts++; if (blk_addr !== 32'd11 || idle_o !== 1'b0) begin failures++; $display("FAIL abort_kept: got blk=%h idle=%b expected 0000000b/0", blk_addr, idle_o); end
        spi.SD_cs = 1'b0;
        #(100);
        send_cmd(6'd58, 32'd0, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            xfer(8'hFF, rx);
            asserts++; if (rx !== e58[i]) begin failures++; $display("FAIL abort_cmd58[%0d]: got %h expected %h", i, rx, e58[i]); end
        end
    endtask

    // Sequencer
    initial begin
        spi.SD_clk    = 1'b0;
        spi.SD_cs     = 1'b1;
        spi.SD_datain = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_ff();
        test_cmd0();
        test_cmd8_cmd58();
        test_illegal_read();
        test_acmd41();
        test_read();
        test_write();
        test_abort();
        spi.SD_cs = 1'b1;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
